// File: rtl/pdm_cic_array.sv
// Multi-line PDM front end: mic clock, dual-edge capture, per-slot CIC
// decimators and a framed valid/ready output with overrun flag.
module pdm_cic_array #(
    parameter int p_channels = 2,
    parameter int p_stages   = 3,
    parameter int p_delay    = 1,
    parameter int p_decim    = 16,
    parameter int p_width    = 16,
    parameter int p_clkdiv   = 2
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic                            i_enable,
    input  logic [p_channels-1:0]           i_data,
    output logic                            o_clk,
    output logic [2*p_channels*p_width-1:0] o_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_overrun
);

    localparam int S  = 2 * p_channels;
    localparam int W  = 2 + p_stages * $clog2(p_decim * p_delay);
    localparam int DW = (p_clkdiv > 1) ? $clog2(p_clkdiv) : 1;
    localparam int BW = $clog2(p_decim);
    localparam int WU = p_stages * p_delay;
    localparam int WW = $clog2(WU + 1);

    typedef logic signed [W-1:0] acc_t;

    logic            clr;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic            samp_r;
    logic            samp_f;
    logic [BW-1:0]   bit_cnt;
    logic            frame_end;
    logic [p_stages:0] vld;
    logic [WW-1:0]   warm;
    logic            present;
    logic [S-1:0]    hit;
    logic [S*p_width-1:0] scaled;

    acc_t xin   [S];
    acc_t integ [S][p_stages];
    acc_t cv    [p_stages][S];
    acc_t cin   [p_stages][S];
    acc_t dl    [p_stages][S][p_delay];

    assign clr       = !i_reset_n || !i_enable;
    assign tick      = (div_cnt == DW'(p_clkdiv - 1));
    assign samp_r    = tick && o_clk;
    assign samp_f    = tick && !o_clk;
    assign frame_end = samp_r && (bit_cnt == BW'(p_decim - 1));
    assign present   = vld[p_stages] && (warm == WW'(WU));

    always_comb begin
        for (int s = 0; s < S; s++) begin
            hit[s] = ((s % 2) == 0) ? samp_r : samp_f;
            xin[s] = i_data[s/2] ? acc_t'(1) : '1;
        end
    end

    // Stage 0 reads the last integrator directly; that register is the latch.
    always_comb begin
        for (int i = 0; i < p_stages; i++) begin
            for (int s = 0; s < S; s++) begin
                if (i == 0) cin[i][s] = integ[s][p_stages-1];
                else        cin[i][s] = cv[i-1][s];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            o_clk     <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            vld       <= '0;
            warm      <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            for (int s = 0; s < S; s++) begin
                for (int i = 0; i < p_stages; i++) begin
                    integ[s][i] <= '0;
                    cv[i][s]    <= '0;
                    for (int j = 0; j < p_delay; j++) dl[i][s][j] <= '0;
                end
            end
        end else begin
            if (tick) begin
                div_cnt <= '0;
                o_clk   <= ~o_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (samp_r) bit_cnt <= bit_cnt + 1'b1;
            for (int s = 0; s < S; s++) begin
                if (hit[s]) begin
                    integ[s][0] <= integ[s][0] + xin[s];
                    for (int i = 1; i < p_stages; i++)
                        integ[s][i] <= integ[s][i] + integ[s][i-1];
                end
            end
            vld <= {vld[p_stages-1:0], frame_end};
            for (int i = 0; i < p_stages; i++) begin
                if (vld[i]) begin
                    for (int s = 0; s < S; s++) begin
                        cv[i][s] <= cin[i][s] - dl[i][s][p_delay-1];
                        for (int j = p_delay - 1; j > 0; j--)
                            dl[i][s][j] <= dl[i][s][j-1];
                        dl[i][s][0] <= cin[i][s];
                    end
                end
            end
            o_overrun <= 1'b0;
            if (present) begin
                o_valid   <= 1'b1;
                o_overrun <= o_valid && !i_ready;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (vld[p_stages] && !present) warm <= warm + 1'b1;
        end
    end

    // Disable keeps the last frame visible; only reset clears it.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)              o_data <= '0;
        else if (i_enable && present) o_data <= scaled;
    end

    for (genvar s = 0; s < S; s++) begin : g_scale
        if (W >= p_width) begin : g_trunc
            assign scaled[s*p_width +: p_width] =
                cv[p_stages-1][s][W-1 -: p_width];
        end else begin : g_sext
            assign scaled[s*p_width +: p_width] =
                {{(p_width-W){cv[p_stages-1][s][W-1]}}, cv[p_stages-1][s]};
        end
    end

endmodule
